tx_pulse_delay: RTL and testbench



---
 rtl/tx_pulse_delay.sv | 216 +++++++++++++++++++++
 tb/tb_tx_pulse_delay.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pulse_delay.sv
// tx_pulse_delay: per-element transmit firing. On fire, waits a latched delay,
// then drives N bipolar cycles (pulse_p half, dead, pulse_n half, dead) and
// strobes done. All outputs are registered.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for fire; latches delay/half_period/num_cycles
// S_WAIT   | counting down the firing delay
// S_POS    | pulse_p high for H cycles
// S_DEAD_A | both drives low for DEAD_TIME cycles
// S_NEG    | pulse_n high for H cycles
// S_DEAD_B | both drives low for DEAD_TIME cycles, then next cycle or finish
// S_FINISH | one-cycle done strobe, busy low
module tx_pulse_delay #(
    parameter int DELAY_WIDTH  = 8,
    parameter int HALF_WIDTH   = 4,
    parameter int CYCLES_WIDTH = 4,
    parameter int DEAD_TIME    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fire,
    input  logic                    abort,
    input  logic [DELAY_WIDTH-1:0]  delay,
    input  logic [HALF_WIDTH-1:0]   half_period,
    input  logic [CYCLES_WIDTH-1:0] num_cycles,
    output logic                    pulse_p,
    output logic                    pulse_n,
    output logic                    busy,
    output logic                    done
);

    localparam int DT_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [DT_W-1:0] DT_LOAD = (DEAD_TIME > 0) ? DT_W'(DEAD_TIME - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_POS,
        S_DEAD_A,
        S_NEG,
        S_DEAD_B,
        S_FINISH
    } state_t;

    state_t                  r_state;
    logic [DELAY_WIDTH-1:0]  r_dly_cnt;
    logic [HALF_WIDTH-1:0]   r_half_cnt;
    logic [DT_W-1:0]         r_dead_cnt;
    logic [CYCLES_WIDTH-1:0] r_cyc_cnt;
    logic [HALF_WIDTH-1:0]   r_h;
    logic [CYCLES_WIDTH-1:0] r_n;
    logic                    r_pulse_p;
    logic                    r_pulse_n;
    logic                    r_busy;
    logic                    r_done;

    logic [HALF_WIDTH-1:0]   w_half_in;
    logic [CYCLES_WIDTH:0]   w_cyc_inc;
    logic                    w_last_cycle;

    // Half-period of zero behaves as one; last-cycle test done one bit wider
    // so a full-scale num_cycles cannot wrap.
    always_comb begin
        w_half_in    = (half_period == '0) ? HALF_WIDTH'(1) : half_period;
        w_cyc_inc    = {1'b0, r_cyc_cnt} + (CYCLES_WIDTH+1)'(1);
        w_last_cycle = (w_cyc_inc >= {1'b0, r_n});
    end

    // Sequencer: reset over abort over fire; every output is a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dly_cnt  <= '0;
            r_half_cnt <= '0;
            r_dead_cnt <= '0;
            r_cyc_cnt  <= '0;
            r_h        <= '0;
            r_n        <= '0;
            r_pulse_p  <= 1'b0;
            r_pulse_n  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_dly_cnt  <= '0;
            r_half_cnt <= '0;
            r_dead_cnt <= '0;
            r_cyc_cnt  <= '0;
            r_pulse_p  <= 1'b0;
            r_pulse_n  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (fire) begin
                        r_h       <= w_half_in;
                        r_n       <= num_cycles;
                        r_cyc_cnt <= '0;
                        if (delay != '0) begin
                            r_state   <= S_WAIT;
                            r_dly_cnt <= delay - DELAY_WIDTH'(1);
                            r_busy    <= 1'b1;
                        end else if (num_cycles == '0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_POS;
                            r_half_cnt <= w_half_in - HALF_WIDTH'(1);
                            r_pulse_p  <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_dly_cnt == '0) begin
                        if (r_n == '0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_POS;
                            r_half_cnt <= r_h - HALF_WIDTH'(1);
                            r_pulse_p  <= 1'b1;
                        end
                    end else begin
                        r_dly_cnt <= r_dly_cnt - DELAY_WIDTH'(1);
                    end
                end
                S_POS: begin
                    if (r_half_cnt == '0) begin
                        r_pulse_p <= 1'b0;
                        if (DEAD_TIME == 0) begin
                            r_state    <= S_NEG;
                            r_half_cnt <= r_h - HALF_WIDTH'(1);
                            r_pulse_n  <= 1'b1;
                        end else begin
                            r_state    <= S_DEAD_A;
                            r_dead_cnt <= DT_LOAD;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt - HALF_WIDTH'(1);
                    end
                end
                S_DEAD_A: begin
                    if (r_dead_cnt == '0) begin
                        r_state    <= S_NEG;
                        r_half_cnt <= r_h - HALF_WIDTH'(1);
                        r_pulse_n  <= 1'b1;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - DT_W'(1);
                    end
                end
                S_NEG: begin
                    if (r_half_cnt == '0) begin
                        r_pulse_n <= 1'b0;
                        if (DEAD_TIME == 0) begin
                            r_cyc_cnt <= w_cyc_inc[CYCLES_WIDTH-1:0];
                            if (w_last_cycle) begin
                                r_state <= S_FINISH;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state    <= S_POS;
                                r_half_cnt <= r_h - HALF_WIDTH'(1);
                                r_pulse_p  <= 1'b1;
                            end
                        end else begin
                            r_state    <= S_DEAD_B;
                            r_dead_cnt <= DT_LOAD;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt - HALF_WIDTH'(1);
                    end
                end
                S_DEAD_B: begin
                    if (r_dead_cnt == '0) begin
                        r_cyc_cnt <= w_cyc_inc[CYCLES_WIDTH-1:0];
                        if (w_last_cycle) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= S_POS;
                            r_half_cnt <= r_h - HALF_WIDTH'(1);
                            r_pulse_p  <= 1'b1;
                        end
                    end else begin
                        r_dead_cnt <= r_dead_cnt - DT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pulse_p <= 1'b0;
                    r_pulse_n <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_p = r_pulse_p;
    assign pulse_n = r_pulse_n;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_tx_pulse_delay.sv
// Bench for tx_pulse_delay: two instances (DEAD_TIME=1 and DEAD_TIME=0) on
// shared inputs, a table of bursts checked cycle by cycle, and hand sequences
// for refire, fire-after-done, abort and mid-burst reset.
module tb_tx_pulse_delay;

    logic       clk = 1'b0;
    logic       reset, fire, abort;
    logic [7:0] delay;
    logic [3:0] half_period, num_cycles;
    logic       p1, n1, b1, d1;
    logic       p0, n0, b0, d0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tx_pulse_delay #(.DELAY_WIDTH(8), .HALF_WIDTH(4), .CYCLES_WIDTH(4), .DEAD_TIME(1)) dut1 (
        .clk(clk), .reset(reset), .fire(fire), .abort(abort), .delay(delay),
        .half_period(half_period), .num_cycles(num_cycles),
        .pulse_p(p1), .pulse_n(n1), .busy(b1), .done(d1));

    tx_pulse_delay #(.DELAY_WIDTH(8), .HALF_WIDTH(4), .CYCLES_WIDTH(4), .DEAD_TIME(0)) dut0 (
        .clk(clk), .reset(reset), .fire(fire), .abort(abort), .delay(delay),
        .half_period(half_period), .num_cycles(num_cycles),
        .pulse_p(p0), .pulse_n(n0), .busy(b0), .done(d0));

    typedef struct {
        int d;
        int h;
        int n;
        int done1;   // expected done offset after fire edge, DEAD_TIME=1
        int done0;   // expected done offset after fire edge, DEAD_TIME=0
        int npulse;  // expected pulse_p (and pulse_n) high cycles
        bit refire;  // extra fires in WAIT and NEG plus input scrambling
    } vec_t;

    vec_t vecs[7];

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at cycle offset t after the fire edge: {p, n, busy, done}
    function automatic logic [3:0] model(int t, int d, int h, int n, int dt);
        int he, per, doff, u, ph;
        logic p, q;
        he   = (h == 0) ? 1 : h;
        per  = 2 * (he + dt);
        doff = 1 + d + n * per;
        p = 1'b0;
        q = 1'b0;
        if (t > d && t < doff) begin
            u  = t - 1 - d;
            ph = u % per;
            p  = (ph < he);
            q  = (ph >= he + dt) && (ph < 2 * he + dt);
        end
        return {p, q, (t >= 1 && t < doff), (t == doff)};
    endfunction

    task automatic chk_dut(string tag, int t, logic [3:0] e, logic p, logic n, logic b, logic dn);
        chk($sformatf("%s t%0d pulse_p", tag, t), int'(p), int'(e[3]));
        chk($sformatf("%s t%0d pulse_n", tag, t), int'(n), int'(e[2]));
        chk($sformatf("%s t%0d busy", tag, t), int'(b), int'(e[1]));
        chk($sformatf("%s t%0d done", tag, t), int'(dn), int'(e[0]));
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, " dut1 outs"}, int'({p1, n1, b1, d1}), 0);
        chk({tag, " dut0 outs"}, int'({p0, n0, b0, d0}), 0);
    endtask

    task automatic arm(int d, int h, int n);
        delay       = 8'(d);
        half_period = 4'(h);
        num_cycles  = 4'(n);
        fire        = 1'b1;
        step();
        fire = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fire  = 1'b0;
        abort = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Mutual exclusion on every sampled cycle of both instances.
    always @(negedge clk) begin
        if (p1 && n1) $display("FAIL overlap dut1: pulse_p=1 pulse_n=1 required not both");
        if (p0 && n0) $display("FAIL overlap dut0: pulse_p=1 pulse_n=1 required not both");
    end

    initial begin
        int seen1, seen0, cnt_p1, cnt_n1, cnt_p0, cnt_n0, tmax;
        string tag;

        vecs[0] = '{d: 3,   h: 2,  n: 2,  done1: 16,  done0: 12,  npulse: 4,  refire: 0};
        vecs[1] = '{d: 0,   h: 0,  n: 1,  done1: 5,   done0: 3,   npulse: 1,  refire: 0};
        vecs[2] = '{d: 255, h: 1,  n: 0,  done1: 256, done0: 256, npulse: 0,  refire: 0};
        vecs[3] = '{d: 0,   h: 15, n: 1,  done1: 33,  done0: 31,  npulse: 15, refire: 0};
        vecs[4] = '{d: 5,   h: 3,  n: 3,  done1: 30,  done0: 24,  npulse: 9,  refire: 0};
        vecs[5] = '{d: 1,   h: 1,  n: 15, done1: 62,  done0: 32,  npulse: 15, refire: 0};
        vecs[6] = '{d: 3,   h: 2,  n: 2,  done1: 16,  done0: 12,  npulse: 4,  refire: 1};

        reset = 1'b1; fire = 1'b0; abort = 1'b0;
        delay = '0; half_period = '0; num_cycles = '0;
        step();
        chk_quiet("reset held");
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_quiet($sformatf("idle after reset c%0d", i));
        end

        for (int v = 0; v < 7; v++) begin
            seen1 = -1; seen0 = -1;
            cnt_p1 = 0; cnt_n1 = 0; cnt_p0 = 0; cnt_n0 = 0;
            tmax = ((vecs[v].done1 > vecs[v].done0) ? vecs[v].done1 : vecs[v].done0) + 2;
            arm(vecs[v].d, vecs[v].h, vecs[v].n);
            if (vecs[v].refire) begin
                delay = 8'hAA; half_period = 4'h7; num_cycles = 4'h9;
            end
            for (int t = 1; t <= tmax; t++) begin
                tag = $sformatf("v%0d", v);
                chk_dut({tag, " dut1"}, t, model(t, vecs[v].d, vecs[v].h, vecs[v].n, 1), p1, n1, b1, d1);
                chk_dut({tag, " dut0"}, t, model(t, vecs[v].d, vecs[v].h, vecs[v].n, 0), p0, n0, b0, d0);
                if (d1 && seen1 < 0) seen1 = t;
                if (d0 && seen0 < 0) seen0 = t;
                cnt_p1 += int'(p1); cnt_n1 += int'(n1);
                cnt_p0 += int'(p0); cnt_n0 += int'(n0);
                fire = vecs[v].refire && (t == 2 || t == 7);
                step();
            end
            fire = 1'b0;
            chk($sformatf("v%0d dut1 done offset", v), seen1, vecs[v].done1);
            chk($sformatf("v%0d dut0 done offset", v), seen0, vecs[v].done0);
            chk($sformatf("v%0d dut1 p count", v), cnt_p1, vecs[v].npulse);
            chk($sformatf("v%0d dut1 n count", v), cnt_n1, vecs[v].npulse);
            chk($sformatf("v%0d dut0 p count", v), cnt_p0, vecs[v].npulse);
            chk($sformatf("v%0d dut0 n count", v), cnt_n0, vecs[v].npulse);
        end

        // Fire in done cycle ignored, fire in following cycle accepted (dut1).
        do_reset();
        arm(0, 1, 1);
        for (int t = 1; t <= 7; t++) begin
            if (t == 5) chk("fad done cycle", int'(d1), 1);
            if (t == 6) chk("fad busy after ignored fire", int'(b1), 0);
            if (t == 7) begin
                chk("fad busy after accepted fire", int'(b1), 1);
                chk("fad pulse_p after accepted fire", int'(p1), 1);
            end
            fire = (t == 5 || t == 6);
            step();
        end
        fire = 1'b0;

        // Abort during first POS of a 4-cycle burst; POS spans t=3..5.
        do_reset();
        arm(2, 3, 4);
        for (int t = 1; t <= 4; t++) begin
            if (t == 4) begin
                chk("abort pre dut1 pulse_p", int'(p1), 1);
                chk("abort pre dut0 pulse_p", int'(p0), 1);
            end
            abort = (t == 4);
            step();
        end
        abort = 1'b0;
        chk_quiet("abort next cycle");
        seen1 = 0;
        for (int t = 0; t < 40; t++) begin
            seen1 += int'(d1) + int'(d0) + int'(p1) + int'(n1) + int'(p0) + int'(n0) + int'(b1) + int'(b0);
            step();
        end
        chk("abort quiet afterwards", seen1, 0);

        // Reset asserted while in NEG (cycle 7 for both instances).
        do_reset();
        arm(0, 4, 2);
        for (int t = 1; t <= 7; t++) begin
            if (t == 7) begin
                chk("rst pre dut1 pulse_n", int'(n1), 1);
                chk("rst pre dut0 pulse_n", int'(n0), 1);
            end
            reset = (t == 7);
            step();
        end
        reset = 1'b0;
        chk_quiet("reset mid-NEG next cycle");
        for (int t = 0; t < 10; t++) begin
            step();
            chk_quiet($sformatf("after mid reset c%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
